fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
//  Downstream consumer of the K-bit synchronous fifo. Pops one word at a time
//  through the fifo read port and transmits it on a single serial line as a
//  UART-style frame: start bit, K data bits LSB first, optional parity, stop bit.
//  Sits between the fifo read side (read/dout/empty) and the board serial pin.
// PARAMETERS
//  K            8  data word width; must match the fifo K
//  CLKS_PER_BIT 4  clk cycles per serial bit; >=1 (small default for simulation)
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst         in   1  asynchronous, active-high reset
//  fifo_empty  in   1  fifo empty flag
//  fifo_dout   in   K  fifo read data; valid the cycle after fifo_read is sampled
//  fifo_read   out  1  fifo read request; one-cycle pulse per popped word
//  txd         out  1  serial output; idle level 1
//  busy        out  1  high whenever state != IDLE
//  frame_done  out  1  one-cycle pulse in the last cycle of the stop bit
// BEHAVIOUR
//  Reset: state=IDLE, txd=1, fifo_read=0, busy=0, frame_done=0; shift register,
//   baud counter and bit counter cleared. Reset mid-frame aborts the frame
//   immediately: txd returns to 1 asynchronously and no partial word is retried.
//  FSM states, with registered transitions:
//   IDLE  : txd=1. If fifo_empty==0 at the edge -> POP. Otherwise stay in IDLE.
//   POP   : fifo_read=1 for exactly this cycle. Always -> LOAD.
//   LOAD  : capture fifo_dout into the shift register. Always -> START.
//   START : txd=0 for CLKS_PER_BIT cycles -> DATA.
//   DATA  : txd=shreg[0] for CLKS_PER_BIT cycles. Then shift right.
//           After K bits -> PARITY if enabled, else -> STOP.
//   PARITY: txd = XOR of the captured word for CLKS_PER_BIT cycles -> STOP.
//   STOP  : txd=1 for CLKS_PER_BIT cycles. frame_done=1 in the final cycle.
//           Then -> IDLE.
//  fifo_read is decoded from state==POP, so it never asserts while
//   fifo_empty=1 was sampled. fifo_empty and fifo_dout are ignored outside
//   IDLE and LOAD, respectively.
//  Latency: fifo_empty sampled low at edge t -> fifo_read high during [t,t+1)
//   -> word captured at t+2 -> txd falls after t+2.
//  Back-to-back words: 3 cycles at txd=1 between a stop bit and the next start
//   bit (IDLE, POP, LOAD). Pop count equals frame count exactly.
//  Frame length from entry to START: (K+2)*CLKS_PER_BIT cycles, or
//   (K+3)*CLKS_PER_BIT with parity.
//  Baud counter: width $clog2(CLKS_PER_BIT+1). Loads CLKS_PER_BIT-1 on each
//   bit boundary and counts down to 0. With CLKS_PER_BIT=1, each bit lasts
//   one cycle.
//  Bit counter: width $clog2(K+1). It never wraps past K.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state is present and emits one even
//   parity bit after the data bits.
//  UART_TX_PARITY_EN undefined: PARITY state and its logic are removed;
//   DATA -> STOP directly.
// TESTING (K=8, CLKS_PER_BIT=4)
//  1 rst=1, then release with fifo_empty=1 for 20 cycles -> txd=1,
//    fifo_read=0, busy=0, frame_done=0 throughout.
//  2 one word 8'hA5 -> exactly one fifo_read pulse. txd bits 0,1,0,1,0,0,1,0,1,1
//    each 4 cycles (40 cycles); frame_done pulses once, then busy=0.
//  3 fifo preloaded with 1,2,3,4 -> 4 fifo_read pulses and 4 frames carrying
//    1..4 LSB first, with a 3-cycle txd=1 gap between frames. Stop in IDLE once
//    empty.
//  4 rst pulse during DATA bit 3 of 8'hFF -> txd=1 and busy=0 immediately.
//    With fifo_empty=1 after release, no fifo_read.
//  5 UART_TX_PARITY_EN defined, word 8'h07 -> parity bit 1 and frame 44 cycles.
//    Undefined -> frame 40 cycles with no parity bit.
//  6 fifo_empty rises mid-frame, then falls during STOP -> current frame
//    completes unchanged. The next fifo_read comes only from IDLE, one cycle
//    after the stop bit ends.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a K-bit synchronous fifo and sends each one
// as a UART frame (start, K data bits LSB first, optional parity, stop).
// Optional feature macro: UART_TX_PARITY_EN adds one even-parity bit per frame.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line idle (txd=1); waits for fifo_empty low
// POP    | fifo_read pulse; fifo presents the word next cycle
// LOAD   | fifo_dout captured into shreg; baud/bit counters preset
// START  | start bit, txd=0 for CLKS_PER_BIT cycles
// DATA   | data bits, txd=shreg[0], shift right on each bit boundary
// PARITY | even parity of the captured word (UART_TX_PARITY_EN only)
// STOP   | stop bit, txd=1; frame_done in its last cycle
module fifo_uart_tx #(
  parameter int K            = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fifo_empty,
  input  logic [K-1:0] fifo_dout,
  output logic         fifo_read,
  output logic         txd,
  output logic         busy,
  output logic         frame_done
);

  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam int CW = $clog2(K + 1);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(K - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, POP, LOAD, START, DATA, STOP, PARITY
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, POP, LOAD, START, DATA, STOP
  } state_t;
`endif

  state_t         state, state_nxt;
  logic [BW-1:0]  baud_cnt, baud_nxt;
  logic [CW-1:0]  bit_cnt, bit_nxt;
  logic [K-1:0]   shreg, shreg_nxt;
  logic           baud_tc;
`ifdef UART_TX_PARITY_EN
  logic           par_bit, par_nxt;
`endif

  // terminal count of the baud down-counter marks the last cycle of a bit
  assign baud_tc = (baud_cnt == '0);

  // state and datapath registers; reset aborts any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= shreg_nxt;
`ifdef UART_TX_PARITY_EN
      par_bit  <= par_nxt;
`endif
    end
  end

  // next-state, counter updates and outputs decoded from the current state;
  // txd is decoded from state so an async reset forces the line high at once
  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud_cnt;
    bit_nxt    = bit_cnt;
    shreg_nxt  = shreg;
`ifdef UART_TX_PARITY_EN
    par_nxt    = par_bit;
`endif
    txd        = 1'b1;
    fifo_read  = 1'b0;
    frame_done = 1'b0;
    busy       = (state != IDLE);

    case (state)
      IDLE: begin
        if (!fifo_empty) state_nxt = POP;
      end

      POP: begin
        fifo_read = 1'b1;
        state_nxt = LOAD;
      end

      LOAD: begin
        shreg_nxt = fifo_dout;
`ifdef UART_TX_PARITY_EN
        par_nxt   = ^fifo_dout;
`endif
        baud_nxt  = BAUD_LOAD;
        bit_nxt   = '0;
        state_nxt = START;
      end

      START: begin
        txd = 1'b0;
        if (baud_tc) begin
          baud_nxt  = BAUD_LOAD;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt - 1'b1;
        end
      end

      DATA: begin
        txd = shreg[0];
        if (baud_tc) begin
          baud_nxt  = BAUD_LOAD;
          shreg_nxt = shreg >> 1;
          bit_nxt   = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          baud_nxt = baud_cnt - 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd = par_bit;
        if (baud_tc) begin
          baud_nxt  = BAUD_LOAD;
          state_nxt = STOP;
        end else begin
          baud_nxt = baud_cnt - 1'b1;
        end
      end
`endif

      STOP: begin
        txd = 1'b1;
        if (baud_tc) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end else begin
          baud_nxt = baud_cnt - 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
